led_frame_sequencer: RTL and testbench



---
 rtl/led_frame_sequencer_pkg.sv | 16 +
 rtl/led_frame_sequencer_gap_timer.sv | 34 +++
 rtl/led_frame_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_led_frame_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_sequencer_pkg.sv
// Shared definitions for the LED frame sequencer: state encoding and
// default frame/gap sizing.
package led_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_FORWARD = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam int FRAME_BITS_DEF = 32;
    localparam int GAP_CYCLES_DEF = 64;
    localparam int FWD_CNT_W_DEF  = 8;

endpackage

// File: rtl/led_frame_sequencer_gap_timer.sv
// Idle-gap timer: counts clk cycles since the last bit strobe and flags
// timeout once GAP_CYCLES strobe-free cycles have elapsed.
module led_gap_timer
    import led_frame_sequencer_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic timeout
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] gap_cnt_r;

    // Gap counter: strobe clears, otherwise count up and hold at GAP_MAX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt_r <= {CNT_W{1'b0}};
        end else if (strobe) begin
            gap_cnt_r <= {CNT_W{1'b0}};
        end else if (gap_cnt_r != GAP_MAX) begin
            gap_cnt_r <= gap_cnt_r + CNT_W'(1);
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    assign timeout = (gap_cnt_r == GAP_MAX);

endmodule

// File: rtl/led_frame_sequencer.sv
// Routes decoded Manchester bits: the first FRAME_BITS of a frame go to the
// local colour register, later bits are forwarded down the LED chain.
module led_frame_sequencer
    import led_frame_sequencer_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int FWD_CNT_W  = FWD_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_strobe,
    input  logic                 in_data,
    input  logic                 in_error,
    input  logic                 in_sync,
    input  logic                 parity_ok,
    output logic                 own_strobe,
    output logic                 own_data,
    output logic                 store,
    output logic                 fwd_strobe,
    output logic                 fwd_data,
    output logic                 fwd_enable,
    output logic                 error,
    output logic [1:0]           state,
    output logic [FWD_CNT_W-1:0] fwd_count
);

    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);
    localparam logic [FWD_CNT_W-1:0] FWD_MAX  = {FWD_CNT_W{1'b1}};

    state_t                 state_r, state_s;
    logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_s, bit_cnt_inc_s;
    logic [FWD_CNT_W-1:0]   fwd_count_r, fwd_count_s;
    logic                   own_strobe_r, own_strobe_s;
    logic                   own_data_r, own_data_s;
    logic                   store_r, store_s;
    logic                   fwd_strobe_r, fwd_strobe_s;
    logic                   fwd_data_r, fwd_data_s;
    logic                   fwd_enable_r, fwd_enable_s;
    logic                   error_r, error_s;
    logic                   link_bad_s, bad_bit_s, timeout_s;

    led_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe  (in_strobe),
        .timeout (timeout_s)
    );

    assign link_bad_s    = in_error | ~in_sync;
    assign bad_bit_s     = in_strobe & link_bad_s;
    assign bit_cnt_inc_s = bit_cnt_r + BIT_CNT_W'(1);

    // Next-state and next-output logic; a link fault outranks any bit or timeout.
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        fwd_count_s  = fwd_count_r;
        own_strobe_s = 1'b0;
        own_data_s   = own_data_r;
        store_s      = 1'b0;
        fwd_strobe_s = 1'b0;
        fwd_data_s   = fwd_data_r;
        fwd_enable_s = 1'b0;
        error_s      = error_r;

        case (state_r)
            ST_IDLE: begin
                error_s = 1'b0;
                if (bad_bit_s) begin
                    state_s = ST_FAULT;
                    error_s = 1'b1;
                end else if (in_strobe) begin
                    state_s      = ST_OWN;
                    bit_cnt_s    = BIT_CNT_W'(1);
                    fwd_count_s  = {FWD_CNT_W{1'b0}};
                    own_strobe_s = 1'b1;
                    own_data_s   = in_data;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (link_bad_s) begin
                    state_s = ST_FAULT;
                    error_s = 1'b1;
                end else if (in_strobe) begin
                    bit_cnt_s    = bit_cnt_inc_s;
                    own_strobe_s = 1'b1;
                    own_data_s   = in_data;
                    if (bit_cnt_inc_s == LAST_BIT) begin
                        // Store only a parity-clean word; a bad word still hands over to forwarding.
                        state_s = ST_FORWARD;
                        store_s = parity_ok;
                        error_s = ~parity_ok;
                    end else begin
                        state_s = ST_OWN;
                    end
                end else if (timeout_s) begin
                    // Short frame: error is a single-cycle pulse, cleared again in IDLE.
                    state_s = ST_IDLE;
                    error_s = 1'b1;
                end else begin
                    state_s = ST_OWN;
                end
            end
            ST_FORWARD: begin
                if (link_bad_s) begin
                    state_s = ST_FAULT;
                    error_s = 1'b1;
                end else if (in_strobe) begin
                    fwd_enable_s = 1'b1;
                    fwd_strobe_s = 1'b1;
                    fwd_data_s   = in_data;
                    if (fwd_count_r != FWD_MAX) begin
                        fwd_count_s = fwd_count_r + FWD_CNT_W'(1);
                    end else begin
                        fwd_count_s = fwd_count_r;
                    end
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                    error_s = 1'b0;
                end else begin
                    fwd_enable_s = 1'b1;
                end
            end
            ST_FAULT: begin
                error_s = 1'b1;
                if (!in_strobe && timeout_s) begin
                    state_s = ST_IDLE;
                    error_s = 1'b0;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_FAULT;
                error_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {BIT_CNT_W{1'b0}};
            fwd_count_r  <= {FWD_CNT_W{1'b0}};
            own_strobe_r <= 1'b0;
            own_data_r   <= 1'b0;
            store_r      <= 1'b0;
            fwd_strobe_r <= 1'b0;
            fwd_data_r   <= 1'b0;
            fwd_enable_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            fwd_count_r  <= fwd_count_s;
            own_strobe_r <= own_strobe_s;
            own_data_r   <= own_data_s;
            store_r      <= store_s;
            fwd_strobe_r <= fwd_strobe_s;
            fwd_data_r   <= fwd_data_s;
            fwd_enable_r <= fwd_enable_s;
            error_r      <= error_s;
        end
    end

    assign own_strobe = own_strobe_r;
    assign own_data   = own_data_r;
    assign store      = store_r;
    assign fwd_strobe = fwd_strobe_r;
    assign fwd_data   = fwd_data_r;
    assign fwd_enable = fwd_enable_r;
    assign error      = error_r;
    assign state      = state_r;
    assign fwd_count  = fwd_count_r;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: stimulus pushes expected own and
// forwarded bits into queues, a negedge monitor pops and compares them.
module tb_led_frame_sequencer;

    localparam int GAP = 64;

    logic       clk = 1'b0;
    logic       rst_n, in_strobe, in_data, in_error, in_sync, parity_ok;
    logic       own_strobe, own_data, store, fwd_strobe, fwd_data, fwd_enable, error;
    logic [1:0] state;
    logic [7:0] fwd_count;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] own_q[$];
    logic       fwd_q[$];
    logic [1:0] exp_own;
    logic       exp_fwd;
    logic [39:0] fpat = 40'h9C_3E5A_71B2;

    led_frame_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_strobe  (in_strobe),
        .in_data    (in_data),
        .in_error   (in_error),
        .in_sync    (in_sync),
        .parity_ok  (parity_ok),
        .own_strobe (own_strobe),
        .own_data   (own_data),
        .store      (store),
        .fwd_strobe (fwd_strobe),
        .fwd_data   (fwd_data),
        .fwd_enable (fwd_enable),
        .error      (error),
        .state      (state),
        .fwd_count  (fwd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every own/forward strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (own_strobe) begin
            if (own_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL own_unexpected: got own bit %0b store %0b expected none", own_data, store);
            end else begin
                exp_own = own_q.pop_front();
                check("own_bit_store", 32'({own_data, store}), 32'(exp_own));
            end
        end
        if (fwd_strobe) begin
            if (fwd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fwd_unexpected: got fwd bit %0b expected none", fwd_data);
            end else begin
                exp_fwd = fwd_q.pop_front();
                check("fwd_bit", 32'(fwd_data), 32'(exp_fwd));
            end
        end
        if (own_strobe || store) begin
            check("own_gating", 32'({fwd_enable, store & ~own_strobe}), 32'd0);
        end
    end

    task automatic drive(input logic d, input logic err, input logic sync, input logic par, input logic stb);
        @(negedge clk);
        in_strobe = stb; in_data = d; in_error = err; in_sync = sync; parity_ok = par;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_own(input logic d, input logic last, input logic par);
        own_q.push_back({d, last & par});
        drive(d, 1'b0, 1'b1, par, 1'b1);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic par);
        for (int i = 0; i < 32; i++) send_own(w[31-i], (i == 31), par);
    endtask

    task automatic send_fwd(input logic d);
        fwd_q.push_back(d);
        drive(d, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; in_strobe = 1'b0; in_data = 1'b0; in_error = 1'b0; in_sync = 1'b1; parity_ok = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({own_strobe, own_data, store, fwd_strobe, fwd_data, fwd_enable, error}), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_fwd_count", 32'(fwd_count), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a frame, then a clean frame.
        w = 32'h1234_5678;
        for (int i = 0; i < 10; i++) send_own(w[31-i], 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; in_strobe = 1'b0;
        @(negedge clk);
        check("midrst_outputs", 32'({own_strobe, own_data, store, fwd_strobe, fwd_data, fwd_enable, error}), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        send_frame(32'hDEAD_BEEF, 1'b1);
        idle(GAP + 2);
        check("after_rst_frame_idle", 32'(state), 32'd0);

        // Nominal frame with 40 forwarded bits.
        send_frame(32'hA5A5_0F0F, 1'b1);
        for (int i = 0; i < 40; i++) begin
            send_fwd(fpat[i]);
            if (i == 0) begin
                check("nom_state_fwd", 32'(state), 32'd2);
                check("nom_enable_low_on_store", 32'(fwd_enable), 32'd0);
            end
            if (i == 1) check("nom_enable_rise", 32'(fwd_enable), 32'd1);
        end
        idle(1);
        check("nom_fwd_count", 32'(fwd_count), 32'd40);
        idle(GAP);
        check("nom_pre_timeout_state", 32'(state), 32'd2);
        idle(1);
        check("nom_timeout_state", 32'(state), 32'd0);
        check("nom_timeout_enable", 32'(fwd_enable), 32'd0);
        check("nom_count_hold", 32'(fwd_count), 32'd40);

        // Parity failure on the last own bit.
        send_frame(32'h0F0F_A5A5, 1'b0);
        idle(1);
        check("par_state", 32'(state), 32'd2);
        check("par_error", 32'(error), 32'd1);
        idle(GAP);
        check("par_error_sticky", 32'(error), 32'd1);
        idle(1);
        check("par_end_state", 32'({state, error}), 32'd0);

        // Short frame of 20 bits.
        for (int i = 0; i < 20; i++) send_own(w[i], 1'b0, 1'b1);
        idle(GAP + 1);
        check("short_pre_state", 32'({state, error}), 32'({2'd1, 1'b0}));
        idle(1);
        check("short_state", 32'(state), 32'd0);
        check("short_error_pulse", 32'(error), 32'd1);
        idle(1);
        check("short_error_clear", 32'(error), 32'd0);

        // Link error while forwarding, plus a strobe during FAULT restarting the gap.
        send_frame(32'h3C3C_C3C3, 1'b1);
        for (int i = 0; i < 5; i++) send_fwd(fpat[i+7]);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("fault_state", 32'(state), 32'd3);
        check("fault_enable_error", 32'({fwd_enable, error}), 32'({1'b0, 1'b1}));
        check("fault_fwd_count", 32'(fwd_count), 32'd5);
        idle(9);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(GAP + 1);
        check("fault_hold_state", 32'(state), 32'd3);
        idle(1);
        check("fault_exit_state", 32'({state, error, fwd_enable}), 32'd0);

        // Strobe exactly at the gap boundary, then saturation over 300 bits.
        send_frame(32'h8001_7FFE, 1'b1);
        send_fwd(fpat[0]);
        idle(GAP);
        for (int i = 1; i < 300; i++) begin
            send_fwd(fpat[i % 40]);
            if (i == 2) check("boundary_alive", 32'({state, fwd_enable}), 32'({2'd2, 1'b1}));
        end
        idle(1);
        check("sat_fwd_count", 32'(fwd_count), 32'd255);
        idle(GAP);
        check("sat_pre_timeout", 32'(state), 32'd2);
        idle(1);
        check("sat_timeout", 32'(state), 32'd0);

        idle(2);
        check("own_queue_drained", 32'(own_q.size()), 32'd0);
        check("fwd_queue_drained", 32'(fwd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
